// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-organised data-memory interface.
// Memory traffic is always a full aligned word; sub-word loads are extracted
// and extended here, sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        done,
  output logic        error,
  output logic [31:0] rdata,
  output logic        memory_read,
  output logic        memory_write,
  output logic [2:0]  option,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic        memory_response,
  input  logic [31:0] read_data
);

  localparam logic [2:0]  F3B  = 3'b000;
  localparam logic [2:0]  F3H  = 3'b001;
  localparam logic [2:0]  F3W  = 3'b010;
  localparam logic [2:0]  F3BU = 3'b100;
  localparam logic [2:0]  F3HU = 3'b101;
  localparam bit          TimeoutEn   = (TIMEOUT != 0);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e      state;
  logic        is_store;
  logic [2:0]  funct3;
  logic [1:0]  offset;
  logic [31:0] wdata;
  logic [31:0] count;

  logic        req_bad;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_value;
  logic [31:0] merged;

  // Reject illegal funct3 or misaligned requests before any memory strobe.
  always_comb begin
    req_bad = 1'b0;
    unique case (req_funct3)
      F3B:        req_bad = 1'b0;
      F3H:        req_bad = req_address[0];
      F3W:        req_bad = (req_address[1:0] != 2'b00);
      F3BU:       req_bad = req_write;
      F3HU:       req_bad = req_write | req_address[0];
      default:    req_bad = 1'b1;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_lane = read_data[7:0];
    unique case (offset)
      2'd0: byte_lane = read_data[7:0];
      2'd1: byte_lane = read_data[15:8];
      2'd2: byte_lane = read_data[23:16];
      2'd3: byte_lane = read_data[31:24];
      default: byte_lane = read_data[7:0];
    endcase
    half_lane = offset[1] ? read_data[31:16] : read_data[15:0];

    load_value = read_data;
    unique case (funct3)
      F3B:     load_value = {{24{byte_lane[7]}}, byte_lane};
      F3H:     load_value = {{16{half_lane[15]}}, half_lane};
      F3BU:    load_value = {24'h0, byte_lane};
      F3HU:    load_value = {16'h0, half_lane};
      default: load_value = read_data;
    endcase

    merged = read_data;
    if (funct3 == F3B) begin
      unique case (offset)
        2'd0: merged[7:0]   = wdata[7:0];
        2'd1: merged[15:8]  = wdata[7:0];
        2'd2: merged[23:16] = wdata[7:0];
        2'd3: merged[31:24] = wdata[7:0];
        default: merged = read_data;
      endcase
    end else if (funct3 == F3H) begin
      if (offset[1]) merged[31:16] = wdata[15:0];
      else           merged[15:0]  = wdata[15:0];
    end
  end

  // Transaction FSM; every interface output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= StIdle;
      is_store     <= 1'b0;
      funct3       <= 3'b000;
      offset       <= 2'b00;
      wdata        <= 32'h0;
      count        <= 32'h0;
      req_ready    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      rdata        <= 32'h0;
      memory_read  <= 1'b0;
      memory_write <= 1'b0;
      option       <= 3'b000;
      address      <= 32'h0;
      write_data   <= 32'h0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_read || req_write) begin
            is_store  <= req_write;
            funct3    <= req_funct3;
            offset    <= req_address[1:0];
            wdata     <= req_wdata;
            count     <= 32'h0;
            req_ready <= 1'b0;
            if (req_bad) begin
              state <= StResp;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              option  <= F3W;
              address <= {req_address[31:2], 2'b00};
              if (req_write && req_funct3 == F3W) begin
                state        <= StWrite;
                memory_write <= 1'b1;
                write_data   <= req_wdata;
              end else begin
                state       <= StRead;
                memory_read <= 1'b1;
              end
            end
          end
        end
        StRead: begin
          if (memory_response) begin
            memory_read <= 1'b0;
            count       <= 32'h0;
            if (is_store) begin
              state        <= StWrite;
              memory_write <= 1'b1;
              write_data   <= merged;
            end else begin
              state   <= StResp;
              rdata   <= load_value;
              done    <= 1'b1;
              option  <= 3'b000;
              address <= 32'h0;
            end
          end else if (TimeoutEn && count == TimeoutLast) begin
            // Aborted read: rdata untouched, no write follows.
            state       <= StResp;
            memory_read <= 1'b0;
            option      <= 3'b000;
            address     <= 32'h0;
            done        <= 1'b1;
            error       <= 1'b1;
          end else begin
            count <= count + 32'd1;
          end
        end
        StWrite: begin
          if (memory_response || (TimeoutEn && count == TimeoutLast)) begin
            state        <= StResp;
            memory_write <= 1'b0;
            write_data   <= 32'h0;
            option       <= 3'b000;
            address      <= 32'h0;
            done         <= 1'b1;
            error        <= ~memory_response;
          end else begin
            count <= count + 32'd1;
          end
        end
        StResp: begin
          state     <= StIdle;
          done      <= 1'b0;
          error     <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
